// File: rtl/dut_mailbox_op_if.sv
// Address-mapped write/read method bundle shared by the mailbox and its driver.
// The master side issues strobes; the slave side returns data and ready.
interface dut_mailbox_op_if #(
    parameter int DW = 8
);
    logic [2:0]    write_address;
    logic [DW-1:0] write_data;
    logic          write_en;
    logic          write_rdy;
    logic [2:0]    read_address;
    logic          read_en;
    logic [DW-1:0] read_data;
    logic          read_rdy;

    // Handshake: a strobe (write_en/read_en) is taken on the rising edge
    // where it is high; rdy is high whenever the block is out of reset.
    modport master (
        output write_address, write_data, write_en, read_address, read_en,
        input  write_rdy, read_data, read_rdy
    );

    modport slave (
        input  write_address, write_data, write_en, read_address, read_en,
        output write_rdy, read_data, read_rdy
    );
endinterface

// File: rtl/dut_mailbox_op.sv
// Operand mailbox: FIFOs A and B feed a bitwise/add combiner whose results
// queue in FIFO Y; all access goes through an address-mapped write/read port.
module dut_mailbox_op #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input logic              CLK,
    input logic              RST_N,
    dut_mailbox_op_if.slave  mb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] a_mem [DEPTH];
    logic [DW-1:0] b_mem [DEPTH];
    logic [DW-1:0] y_mem [DEPTH];
    logic [PW-1:0] a_wp, a_rp, b_wp, b_rp, y_wp, y_rp;
    logic [CW-1:0] a_cnt, b_cnt, y_cnt;
    logic [1:0]    op;
    logic [2:0]    err;
    logic [DW-1:0] rd_q, rd_next;

    logic a_full, b_full, y_full, a_empty, b_empty, y_empty;
    logic wr_a, wr_b, wr_op, push_a, push_b;
    logic rd_y, pop_y, rd_err, combine;
    logic [2:0]    err_new;
    logic [DW-1:0] comb_res;

    // All full/empty decisions use the pre-edge occupancy.
    assign a_full  = (a_cnt == CW'(DEPTH));
    assign b_full  = (b_cnt == CW'(DEPTH));
    assign y_full  = (y_cnt == CW'(DEPTH));
    assign a_empty = (a_cnt == '0);
    assign b_empty = (b_cnt == '0);
    assign y_empty = (y_cnt == '0);

    assign wr_a    = mb.write_en && (mb.write_address == 3'd4);
    assign wr_b    = mb.write_en && (mb.write_address == 3'd5);
    assign wr_op   = mb.write_en && (mb.write_address == 3'd6);
    assign push_a  = wr_a && !a_full;
    assign push_b  = wr_b && !b_full;
    assign rd_y    = mb.read_en && (mb.read_address == 3'd3);
    assign pop_y   = rd_y && !y_empty;
    assign rd_err  = mb.read_en && (mb.read_address == 3'd5);
    assign combine = !a_empty && !b_empty && !y_full;
    assign err_new = {rd_y && y_empty, wr_b && b_full, wr_a && a_full};

    always_comb begin
        comb_res = '0;
        case (op)
            2'd0:    comb_res = a_mem[a_rp] | b_mem[b_rp];
            2'd1:    comb_res = a_mem[a_rp] & b_mem[b_rp];
            2'd2:    comb_res = a_mem[a_rp] ^ b_mem[b_rp];
            default: comb_res = a_mem[a_rp] + b_mem[b_rp];
        endcase
    end

    always_comb begin
        rd_next = rd_q;
        if (mb.read_en) begin
            case (mb.read_address)
                3'd0:    rd_next = DW'(!a_full);
                3'd1:    rd_next = DW'(!b_full);
                3'd2:    rd_next = DW'(!y_empty);
                3'd3:    rd_next = y_empty ? '0 : y_mem[y_rp];
                3'd4:    rd_next = DW'(y_cnt);
                3'd5:    rd_next = DW'(err);
                3'd6:    rd_next = DW'(op);
                default: rd_next = '0;
            endcase
        end
    end

    // Storage arrays need no reset: occupancy counters gate every access.
    always_ff @(posedge CLK) begin
        if (push_a)  a_mem[a_wp] <= mb.write_data;
        if (push_b)  b_mem[b_wp] <= mb.write_data;
        if (combine) y_mem[y_wp] <= comb_res;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_wp  <= '0;
            a_rp  <= '0;
            b_wp  <= '0;
            b_rp  <= '0;
            y_wp  <= '0;
            y_rp  <= '0;
            a_cnt <= '0;
            b_cnt <= '0;
            y_cnt <= '0;
            op    <= '0;
            err   <= '0;
            rd_q  <= '0;
        end else begin
            if (push_a)  a_wp <= a_wp + PW'(1);
            if (push_b)  b_wp <= b_wp + PW'(1);
            if (combine) begin
                a_rp <= a_rp + PW'(1);
                b_rp <= b_rp + PW'(1);
                y_wp <= y_wp + PW'(1);
            end
            if (pop_y)   y_rp <= y_rp + PW'(1);
            a_cnt <= a_cnt + CW'(push_a) - CW'(combine);
            b_cnt <= b_cnt + CW'(push_b) - CW'(combine);
            y_cnt <= y_cnt + CW'(combine) - CW'(pop_y);
            if (wr_op)   op <= mb.write_data[1:0];
            // An ERR read clears old bits but never swallows a same-edge event.
            err  <= (rd_err ? 3'b000 : err) | err_new;
            rd_q <= rd_next;
        end
    end

    assign mb.read_data = rd_q;
    assign mb.write_rdy = RST_N;
    assign mb.read_rdy  = RST_N;
endmodule

// File: tb/tb_dut_mailbox_op.sv
// Directed bench for dut_mailbox_op: operations, back-pressure, errors,
// OP-change timing, simultaneous push/pop and reset behaviour.
module tb_dut_mailbox_op;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [DW-1:0] rv;

    dut_mailbox_op_if #(.DW(DW)) mb ();

    dut_mailbox_op #(.DW(DW), .DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .mb    (mb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [2:0] addr, input logic [DW-1:0] data);
        mb.write_address = addr;
        mb.write_data    = data;
        mb.write_en      = 1'b1;
        @(posedge clk);
        #1;
        mb.write_en      = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, output logic [DW-1:0] data);
        mb.read_address = addr;
        mb.read_en      = 1'b1;
        @(posedge clk);
        #1;
        data            = mb.read_data;
        mb.read_en      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op_pair(input logic [1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] exp, input string tag);
        logic [DW-1:0] d;
        wr(3'd6, {6'd0, op});
        wr(3'd4, a);
        wr(3'd5, b);
        idle(1);
        rd(3'd2, d);
        check({tag, "_nonempty"}, d, 1);
        rd(3'd3, d);
        check(tag, d, exp);
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        rst_n            = 1'b0;
        mb.write_address = '0;
        mb.write_data    = '0;
        mb.write_en      = 1'b0;
        mb.read_address  = '0;
        mb.read_en       = 1'b0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check("por_read_data", mb.read_data, 0);
        check("por_write_rdy", mb.write_rdy, 0);
        check("por_read_rdy", mb.read_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("write_rdy_up", mb.write_rdy, 1);
        check("read_rdy_up", mb.read_rdy, 1);

        // Reset in the middle of traffic.
        wr(3'd6, 8'd2);
        rd(3'd6, rv);
        check("op_readback", rv, 2);
        wr(3'd4, 8'h12);
        wr(3'd5, 8'h34);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_read_data", mb.read_data, 0);
        check("midrst_write_rdy", mb.write_rdy, 0);
        check("midrst_read_rdy", mb.read_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        rd(3'd2, rv);
        check("rst_y_empty", rv, 0);
        rd(3'd5, rv);
        check("rst_err", rv, 0);
        rd(3'd6, rv);
        check("rst_op", rv, 0);

        // Each operation.
        op_pair(2'd0, 8'h0F, 8'hF0, 8'hFF, "or");
        op_pair(2'd1, 8'hF3, 8'h3C, 8'h30, "and");
        op_pair(2'd2, 8'hAA, 8'hFF, 8'h55, "xor");
        op_pair(2'd3, 8'hFF, 8'h02, 8'h01, "add");

        // Back-pressure: fill Y, then A and B, then overflow A.
        wr(3'd6, 8'd0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            wr(3'd4, 8'(i + 1));
            wr(3'd5, 8'((i + 1) << 4));
        end
        idle(1);
        rd(3'd4, rv);
        check("bp_y_count", rv, DEPTH);
        rd(3'd0, rv);
        check("bp_a_not_full", rv, 0);
        rd(3'd1, rv);
        check("bp_b_not_full", rv, 0);
        wr(3'd4, 8'h99);
        rd(3'd5, rv);
        check("bp_err_a_ovf", rv, 1);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            rd(3'd3, rv);
            check($sformatf("bp_pop%0d", i), rv, ((i + 1) << 4) | (i + 1));
        end
        rd(3'd4, rv);
        check("bp_drained", rv, 0);
        rd(3'd5, rv);
        check("bp_err_cleared", rv, 0);

        // Underflow.
        rd(3'd3, rv);
        check("udf_data", rv, 0);
        rd(3'd5, rv);
        check("udf_err", rv, 4);
        rd(3'd5, rv);
        check("udf_err_clear", rv, 0);

        // OP written on the combine edge: that combine still uses XOR.
        wr(3'd6, 8'd2);
        wr(3'd4, 8'h0F);
        wr(3'd5, 8'h01);
        wr(3'd6, 8'd3);
        rd(3'd3, rv);
        check("op_late", rv, 8'h0E);
        rd(3'd6, rv);
        check("op_now_add", rv, 3);
        // OP written before the pair completes: ADD applies.
        wr(3'd6, 8'd2);
        wr(3'd4, 8'h0F);
        wr(3'd6, 8'd3);
        wr(3'd5, 8'h01);
        idle(1);
        rd(3'd3, rv);
        check("op_early", rv, 8'h10);

        // Simultaneous combine push and pop with one entry in Y.
        wr(3'd6, 8'd0);
        wr(3'd4, 8'h01);
        wr(3'd5, 8'h02);
        idle(1);
        wr(3'd4, 8'h04);
        wr(3'd5, 8'h08);
        rd(3'd3, rv);
        check("sim_pop_old", rv, 8'h03);
        rd(3'd4, rv);
        check("sim_count", rv, 1);
        rd(3'd3, rv);
        check("sim_pop_new", rv, 8'h0C);
        rd(3'd7, rv);
        check("addr7_zero", rv, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
